// File: rtl/ratfl_chkpt_ctrl.sv
// Branch checkpoint table holding RAT and free-list snapshots, with mispredict recovery.
// Optional CHKPT_STATS_EN adds mispredict and full-cycle counters.
module ratfl_chkpt_ctrl #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int PREGS  = 64,
    parameter int PREG_W = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  chkpt_we_i,
    input  logic [32*PREG_W-1:0]  chkpt_rat_map_i,
    input  logic [PREG_W-1:0]     chkpt_fl_head_i,
    input  logic [PREG_W-1:0]     chkpt_fl_tail_i,
    input  logic [PREG_W:0]       chkpt_fl_free_count_i,
    output logic [TAG_W-1:0]      chkpt_tag_o,
    output logic                  chkpt_full_o,
    input  logic                  commit_free_valid_i,
    input  logic                  resolve_valid_i,
    input  logic [TAG_W-1:0]      resolve_tag_i,
    input  logic                  resolve_mispredict_i,
    output logic                  rat_recover_o,
    output logic [32*PREG_W-1:0]  rat_recover_map_o,
    output logic                  fl_recover_o,
    output logic [PREG_W-1:0]     fl_recover_head_o,
    output logic [PREG_W-1:0]     fl_recover_tail_o,
    output logic [PREG_W:0]       fl_recover_free_count_o,
    output logic                  overflow_err_o
`ifdef CHKPT_STATS_EN
    ,
    output logic [31:0]           stat_mispredicts_o,
    output logic [31:0]           stat_full_cycles_o
`endif
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int MAP_W = 32 * PREG_W;
    localparam int CNT_W = PREG_W + 1;

    logic [MAP_W-1:0]  map_q       [DEPTH];
    logic [PREG_W-1:0] snap_head_q [DEPTH];
    logic [PREG_W-1:0] snap_tail_q [DEPTH];
    logic [CNT_W-1:0]  snap_cnt_q  [DEPTH];
    logic [CNT_W-1:0]  frees_q     [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d, resolved_q, resolved_d;
    logic [PTR_W-1:0]  head_q, tail_q;
    logic              overflow_q, recover_q;
    logic [MAP_W-1:0]  rec_map_q;
    logic [PREG_W-1:0] rec_head_q, rec_tail_q;
    logic [CNT_W-1:0]  rec_cnt_q;

    logic [IDX_W-1:0]  head_idx, tail_idx, res_idx, mp_off, age;
    logic              full, res_hit, mp, wr_acc, retire;
    logic [CNT_W-1:0]  mp_frees;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_W'(PREGS)) ? v : v + CNT_W'(1);
    endfunction

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
    assign res_idx  = resolve_tag_i[IDX_W-1:0];
    assign res_hit  = resolve_valid_i && ({1'b0, resolve_tag_i} < (TAG_W+1)'(DEPTH)) && valid_q[res_idx];
    assign mp       = res_hit && resolve_mispredict_i;
    // Age of the mispredicted slot relative to head; it and everything at or beyond it is flushed.
    assign mp_off   = res_idx - head_idx;
    assign wr_acc   = chkpt_we_i && !full && !mp;
    assign retire   = valid_q[head_idx] && resolved_q[head_idx] && !(mp && (res_idx == head_idx));
    assign mp_frees = commit_free_valid_i ? sat_inc(frees_q[res_idx]) : frees_q[res_idx];

    always_comb begin
        valid_d    = valid_q;
        resolved_d = resolved_q;
        age        = '0;
        if (res_hit && !resolve_mispredict_i) resolved_d[res_idx] = 1'b1;
        if (retire) begin
            valid_d[head_idx]    = 1'b0;
            resolved_d[head_idx] = 1'b0;
        end
        if (mp) begin
            for (int i = 0; i < DEPTH; i++) begin
                age = IDX_W'(i) - head_idx;
                if (age >= mp_off) begin
                    valid_d[i]    = 1'b0;
                    resolved_d[i] = 1'b0;
                end
            end
        end
        if (wr_acc) begin
            valid_d[tail_idx]    = 1'b1;
            resolved_d[tail_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= '0;
            resolved_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            overflow_q <= 1'b0;
            recover_q  <= 1'b0;
            rec_map_q  <= '0;
            rec_head_q <= '0;
            rec_tail_q <= '0;
            rec_cnt_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            resolved_q <= resolved_d;
            recover_q  <= mp;
            if (mp) begin
                rec_map_q  <= map_q[res_idx];
                rec_head_q <= snap_head_q[res_idx];
                rec_tail_q <= snap_tail_q[res_idx] + mp_frees[PREG_W-1:0];
                rec_cnt_q  <= snap_cnt_q[res_idx] + mp_frees;
                tail_q     <= head_q + PTR_W'(mp_off);
            end else if (wr_acc) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (retire) head_q <= head_q + PTR_W'(1);
            if (chkpt_we_i && full && !mp) overflow_q <= 1'b1;
        end
    end

    // Snapshot payload and free counters; only meaningful while the slot is valid.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (commit_free_valid_i && valid_q[i]) frees_q[i] <= sat_inc(frees_q[i]);
        end
        if (wr_acc) begin
            map_q[tail_idx]       <= chkpt_rat_map_i;
            snap_head_q[tail_idx] <= chkpt_fl_head_i;
            snap_tail_q[tail_idx] <= chkpt_fl_tail_i;
            snap_cnt_q[tail_idx]  <= chkpt_fl_free_count_i;
            frees_q[tail_idx]     <= commit_free_valid_i ? CNT_W'(1) : CNT_W'(0);
        end
    end

`ifdef CHKPT_STATS_EN
    logic [31:0] stat_mp_q, stat_full_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_mp_q   <= '0;
            stat_full_q <= '0;
        end else begin
            if (mp)   stat_mp_q   <= stat_mp_q + 32'd1;
            if (full) stat_full_q <= stat_full_q + 32'd1;
        end
    end
    assign stat_mispredicts_o = stat_mp_q;
    assign stat_full_cycles_o = stat_full_q;
`endif

    assign chkpt_tag_o             = TAG_W'(tail_idx);
    assign chkpt_full_o            = full;
    assign rat_recover_o           = recover_q;
    assign fl_recover_o            = recover_q;
    assign rat_recover_map_o       = rec_map_q;
    assign fl_recover_head_o       = rec_head_q;
    assign fl_recover_tail_o       = rec_tail_q;
    assign fl_recover_free_count_o = rec_cnt_q;
    assign overflow_err_o          = overflow_q;
endmodule

// File: tb/tb_ratfl_chkpt_ctrl.sv
// Self-checking bench for ratfl_chkpt_ctrl: directed scenarios then random traffic against a queue model.
module tb_ratfl_chkpt_ctrl;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 4;
    localparam int PREGS  = 64;
    localparam int PREG_W = 6;
    localparam int MAP_W  = 32 * PREG_W;

    logic                clk = 1'b0;
    logic                rst_ni;
    logic                chkpt_we_i;
    logic [MAP_W-1:0]    chkpt_rat_map_i;
    logic [PREG_W-1:0]   chkpt_fl_head_i, chkpt_fl_tail_i;
    logic [PREG_W:0]     chkpt_fl_free_count_i;
    logic [TAG_W-1:0]    chkpt_tag_o;
    logic                chkpt_full_o;
    logic                commit_free_valid_i;
    logic                resolve_valid_i;
    logic [TAG_W-1:0]    resolve_tag_i;
    logic                resolve_mispredict_i;
    logic                rat_recover_o, fl_recover_o, overflow_err_o;
    logic [MAP_W-1:0]    rat_recover_map_o;
    logic [PREG_W-1:0]   fl_recover_head_o, fl_recover_tail_o;
    logic [PREG_W:0]     fl_recover_free_count_o;
`ifdef CHKPT_STATS_EN
    logic [31:0]         stat_mispredicts_o, stat_full_cycles_o;
`endif

    ratfl_chkpt_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PREGS(PREGS), .PREG_W(PREG_W)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .chkpt_we_i(chkpt_we_i), .chkpt_rat_map_i(chkpt_rat_map_i),
        .chkpt_fl_head_i(chkpt_fl_head_i), .chkpt_fl_tail_i(chkpt_fl_tail_i),
        .chkpt_fl_free_count_i(chkpt_fl_free_count_i),
        .chkpt_tag_o(chkpt_tag_o), .chkpt_full_o(chkpt_full_o),
        .commit_free_valid_i(commit_free_valid_i),
        .resolve_valid_i(resolve_valid_i), .resolve_tag_i(resolve_tag_i),
        .resolve_mispredict_i(resolve_mispredict_i),
        .rat_recover_o(rat_recover_o), .rat_recover_map_o(rat_recover_map_o),
        .fl_recover_o(fl_recover_o), .fl_recover_head_o(fl_recover_head_o),
        .fl_recover_tail_o(fl_recover_tail_o),
        .fl_recover_free_count_o(fl_recover_free_count_o),
        .overflow_err_o(overflow_err_o)
`ifdef CHKPT_STATS_EN
        , .stat_mispredicts_o(stat_mispredicts_o), .stat_full_cycles_o(stat_full_cycles_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Behavioural model: live checkpoints, oldest first.
    typedef struct {
        int             tag;
        logic [MAP_W-1:0] map;
        int             hd, tl, cnt, frees;
        bit             res;
    } ent_t;
    ent_t             mq[$];
    int               next_tag;
    bit               e_rec, e_ovf;
    logic [MAP_W-1:0] e_map;
    int               e_hd, e_tl, e_cnt;

    logic [MAP_W-1:0] s_map;
    int               s_hd, s_tl, s_cnt;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        next_tag = 0;
        e_rec = 0; e_ovf = 0; e_map = '0; e_hd = 0; e_tl = 0; e_cnt = 0;
    endtask

    task automatic new_snap();
        for (int k = 0; k < 6; k++) s_map[k*32 +: 32] = $urandom;
        s_hd  = $urandom_range(0, PREGS-1);
        s_tl  = $urandom_range(0, PREGS-1);
        s_cnt = $urandom_range(0, PREGS);
    endtask

    task automatic check_all();
        chk("full",   256'(chkpt_full_o),   256'(mq.size() == DEPTH));
        chk("tag",    256'(chkpt_tag_o),    256'(next_tag));
        chk("rec",    256'(rat_recover_o),  256'(e_rec));
        chk("flrec",  256'(fl_recover_o),   256'(e_rec));
        chk("ovf",    256'(overflow_err_o), 256'(e_ovf));
        chk("map",    256'(rat_recover_map_o), 256'(e_map));
        chk("rhead",  256'(fl_recover_head_o), 256'(e_hd));
        chk("rtail",  256'(fl_recover_tail_o), 256'(e_tl));
        chk("rcount", 256'(fl_recover_free_count_o), 256'(e_cnt));
    endtask

    task automatic step(input bit we, input bit cf, input bit rv, input int rt, input bit mpr);
        int   p;
        bit   mp, full, retire;
        int   f;
        ent_t e;
        chkpt_we_i = we; chkpt_rat_map_i = s_map;
        chkpt_fl_head_i = PREG_W'(s_hd); chkpt_fl_tail_i = PREG_W'(s_tl);
        chkpt_fl_free_count_i = (PREG_W+1)'(s_cnt);
        commit_free_valid_i = cf; resolve_valid_i = rv;
        resolve_tag_i = TAG_W'(rt); resolve_mispredict_i = mpr;

        p = -1;
        if (rv) foreach (mq[i]) if (mq[i].tag == rt) p = i;
        mp     = (p >= 0) && mpr;
        full   = (mq.size() == DEPTH);
        retire = (mq.size() > 0) && mq[0].res && !(mp && p == 0);
        e_rec  = mp;
        if (mp) begin
            f = mq[p].frees + (cf ? 1 : 0);
            if (f > PREGS) f = PREGS;
            e_map = mq[p].map;
            e_hd  = mq[p].hd;
            e_tl  = (mq[p].tl + f) % PREGS;
            e_cnt = (mq[p].cnt + f) % (2 * PREGS);
        end
        if (we && full && !mp) e_ovf = 1;
        if (cf) foreach (mq[i]) if (mq[i].frees < PREGS) mq[i].frees++;
        if (p >= 0 && !mpr) mq[p].res = 1;
        if (mp) begin
            while (mq.size() > p) void'(mq.pop_back());
            next_tag = rt;
        end
        if (retire) void'(mq.pop_front());
        if (we && !full && !mp) begin
            e.tag = next_tag; e.map = s_map; e.hd = s_hd; e.tl = s_tl; e.cnt = s_cnt;
            e.frees = cf ? 1 : 0; e.res = 0;
            mq.push_back(e);
            next_tag = (next_tag + 1) % DEPTH;
        end

        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        chkpt_we_i = 0; commit_free_valid_i = 0; resolve_valid_i = 0;
        resolve_tag_i = '0; resolve_mispredict_i = 0;
        #2 rst_ni = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clk);
        #1 check_all();
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        chkpt_we_i = 0; chkpt_rat_map_i = '0; chkpt_fl_head_i = '0; chkpt_fl_tail_i = '0;
        chkpt_fl_free_count_i = '0; commit_free_valid_i = 0; resolve_valid_i = 0;
        resolve_tag_i = '0; resolve_mispredict_i = 0;
        model_reset();
        new_snap();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("t1_tag",  256'(chkpt_tag_o), 256'(0));
        chk("t1_full", 256'(chkpt_full_o), 256'(0));
        rst_ni = 1'b1;

        // Fill all slots, then overflow.
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2_tag_seq", 256'(chkpt_tag_o), 256'(i));
            new_snap();
            step(1, 0, 0, 0, 0);
        end
        chk("t2_full", 256'(chkpt_full_o), 256'(1));
        step(1, 0, 0, 0, 0);
        chk("t2_ovf", 256'(overflow_err_o), 256'(1));
        do_reset();

        // Restore with commit frees folded in.
        new_snap();
        s_hd = 5; s_tl = 2; s_cnt = 61;
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1);
        chk("t3_rec",   256'(rat_recover_o), 256'(1));
        chk("t3_head",  256'(fl_recover_head_o), 256'(5));
        chk("t3_tail",  256'(fl_recover_tail_o), 256'(5));
        chk("t3_count", 256'(fl_recover_free_count_o), 256'(64));
        chk("t3_map",   256'(rat_recover_map_o), 256'(s_map));
        idle();
        chk("t3_pulse_end", 256'(rat_recover_o), 256'(0));
        do_reset();

        // Flush younger slots; stale resolve ignored.
        for (int i = 0; i < 3; i++) begin new_snap(); step(1, 0, 0, 0, 0); end
        step(0, 0, 1, 1, 1);
        chk("t4_tag", 256'(chkpt_tag_o), 256'(1));
        step(0, 0, 1, 2, 1);
        chk("t4_stale_rec", 256'(rat_recover_o), 256'(0));
        idle();
        do_reset();

        // Out-of-order correct resolves drain in order.
        for (int i = 0; i < 2; i++) begin new_snap(); step(1, 0, 0, 0, 0); end
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        idle();
        idle();
        for (int i = 0; i < DEPTH; i++) begin new_snap(); step(1, 0, 0, 0, 0); end
        chk("t5_full_after_drain", 256'(chkpt_full_o), 256'(1));
        do_reset();

        // Write colliding with mispredict is dropped.
        new_snap();
        step(1, 0, 0, 0, 0);
        new_snap();
        step(1, 0, 1, 0, 1);
        chk("t6_tag", 256'(chkpt_tag_o), 256'(0));
        chk("t6_ovf", 256'(overflow_err_o), 256'(0));
        chk("t6_rec", 256'(rat_recover_o), 256'(1));
        do_reset();

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            new_snap();
            if ($urandom_range(0, 199) == 0) do_reset();
            else step($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4,
                      $urandom_range(0, 9) < 4, $urandom_range(0, 5),
                      $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
